id_ex_stage: RTL and testbench

//  ID/EX pipeline register with load-use hazard detection for the 5-stage MIPS core.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/id_ex_stage_hazard_detect.sv | 21 ++
 rtl/id_ex_stage.sv | 122 ++++++++++++
 tb/tb_id_ex_stage.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared datapath widths, ALU op encodings and ID/EX control bundle for the 5-stage core.
package mips_pkg;
  localparam int DATA_W  = 32;
  localparam int REG_AW  = 5;
  localparam int ALUOP_W = 4;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8,
    ALU_SRA = 4'd9,
    ALU_LUI = 4'd10
  } alu_op_e;

  typedef struct packed {
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
  } id_ex_ctrl_t;
endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// hazard_detect: load-use compare between the load sitting in EX and the instruction in ID.
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              exValid,
  input  logic              exMemRead,
  input  logic [REG_AW-1:0] exRt,
  input  logic              idValid,
  input  logic              idUsesRs,
  input  logic              idUsesRt,
  input  logic [REG_AW-1:0] idRs,
  input  logic [REG_AW-1:0] idRt,
  input  logic              exFlush,
  output logic              loadUse
);
  logic rsHit, rtHit;
  assign rsHit   = idUsesRs && (idRs == exRt);
  assign rtHit   = idUsesRt && (idRt == exRt);
  // a load into $0 never produces a value worth waiting for; a flushed ID is discarded anyway
  assign loadUse = !exFlush && exValid && exMemRead && (exRt != '0) && idValid && (rsHit || rtHit);
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion, stall hold and flush.
module id_ex_stage #(
  parameter int DATA_W  = mips_pkg::DATA_W,
  parameter int REG_AW  = mips_pkg::REG_AW,
  parameter int ALUOP_W = mips_pkg::ALUOP_W,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               id_uses_rs,
  input  logic               id_uses_rt,
  input  logic               id_reg_dst,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_mem_to_reg,
  input  logic               id_alu_src,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic [DATA_W-1:0]  id_rs_data,
  input  logic [DATA_W-1:0]  id_rt_data,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic               mem_stall,
  input  logic               ex_flush,
  output logic               ex_valid,
  output logic [REG_AW-1:0]  ex_rs,
  output logic [REG_AW-1:0]  ex_rt,
  output logic [REG_AW-1:0]  ex_write_reg,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_mem_to_reg,
  output logic               ex_alu_src,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic [DATA_W-1:0]  ex_rs_data,
  output logic [DATA_W-1:0]  ex_rt_data,
  output logic [DATA_W-1:0]  ex_imm,
  output logic               load_use_stall,
  output logic               pc_write_en,
  output logic               if_id_write_en,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);
  import mips_pkg::*;

  id_ex_ctrl_t       idCtrl, exCtrl;
  logic [REG_AW-1:0] idWriteReg;
  logic              clearStage, holdStage;

  assign idWriteReg = id_reg_dst ? id_rd : id_rt;
  // register writes to $0 are dropped here so forwarding never matches on $0
  assign idCtrl = id_valid ? id_ex_ctrl_t'{
    reg_write:  id_reg_write && (idWriteReg != '0),
    mem_read:   id_mem_read,
    mem_write:  id_mem_write,
    mem_to_reg: id_mem_to_reg,
    alu_src:    id_alu_src,
    alu_op:     id_alu_op
  } : '0;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .exValid  (ex_valid),
    .exMemRead(ex_mem_read),
    .exRt     (ex_rt),
    .idValid  (id_valid),
    .idUsesRs (id_uses_rs),
    .idUsesRt (id_uses_rt),
    .idRs     (id_rs),
    .idRt     (id_rt),
    .exFlush  (ex_flush),
    .loadUse  (load_use_stall)
  );

  assign pc_write_en    = !(load_use_stall || mem_stall);
  assign if_id_write_en = !(load_use_stall || mem_stall);
  // flush outranks a memory stall; a bubble only lands when the pipe is actually moving
  assign clearStage = ex_flush || (!mem_stall && load_use_stall);
  assign holdStage  = mem_stall && !ex_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || clearStage) begin
      ex_valid     <= 1'b0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_write_reg <= '0;
      exCtrl       <= '0;
      ex_rs_data   <= '0;
      ex_rt_data   <= '0;
      ex_imm       <= '0;
    end else if (!holdStage) begin
      ex_valid     <= id_valid;
      ex_rs        <= id_rs;
      ex_rt        <= id_rt;
      ex_write_reg <= idWriteReg;
      exCtrl       <= idCtrl;
      ex_rs_data   <= id_rs_data;
      ex_rt_data   <= id_rt_data;
      ex_imm       <= id_imm;
    end
  end

  assign ex_reg_write  = exCtrl.reg_write;
  assign ex_mem_read   = exCtrl.mem_read;
  assign ex_mem_write  = exCtrl.mem_write;
  assign ex_mem_to_reg = exCtrl.mem_to_reg;
  assign ex_alu_src    = exCtrl.alu_src;
  assign ex_alu_op     = exCtrl.alu_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else if (ex_flush) begin
      flush_cnt  <= flush_cnt + CNT_W'(flush_cnt != '1);
    end else if (!mem_stall && load_use_stall) begin
      bubble_cnt <= bubble_cnt + CNT_W'(bubble_cnt != '1);
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and random checks of id_ex_stage against a behavioural pipeline model.
module tb_id_ex_stage;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic        v;
    logic [4:0]  rs, rt, wr;
    logic        rw, mr, mw, m2r, as;
    logic [3:0]  op;
    logic [31:0] a, b, imm;
  } ex_t;

  logic clk = 0, rst_n = 0;
  logic id_valid, id_uses_rs, id_uses_rt, id_reg_dst;
  logic id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src;
  logic [4:0] id_rs, id_rt, id_rd;
  logic [3:0] id_alu_op;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic mem_stall, ex_flush;
  logic ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src;
  logic [4:0] ex_rs, ex_rt, ex_write_reg;
  logic [3:0] ex_alu_op;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
  logic load_use_stall, pc_write_en, if_id_write_en;
  logic [CW-1:0] bubble_cnt, flush_cnt;

  ex_t m, obs;
  int  bub, fl;
  int  checks = 0, errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_dst(id_reg_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .mem_stall(mem_stall), .ex_flush(ex_flush), .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_write_reg(ex_write_reg), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src),
    .ex_alu_op(ex_alu_op), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .load_use_stall(load_use_stall), .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  assign obs = {ex_valid, ex_rs, ex_rt, ex_write_reg, ex_reg_write, ex_mem_read, ex_mem_write,
                ex_mem_to_reg, ex_alu_src, ex_alu_op, ex_rs_data, ex_rt_data, ex_imm};

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic logic exp_stall();
    return !ex_flush && m.v && m.mr && m.rt != 0 && id_valid &&
           ((id_uses_rs && id_rs == m.rt) || (id_uses_rt && id_rt == m.rt));
  endfunction

  task automatic set_id(input logic v, input logic [4:0] rs, rt, rd, input logic urs, urt, dst, rw, mr);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rs = urs; id_uses_rt = urt;
    id_reg_dst = dst; id_reg_write = rw; id_mem_read = mr;
    id_mem_write = 1'($urandom); id_mem_to_reg = mr; id_alu_src = 1'($urandom);
    id_alu_op = 4'($urandom); id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
  endtask

  task automatic randomize_id();
    set_id(($urandom % 4) != 0, 5'($urandom % 6), 5'($urandom % 6), 5'($urandom % 6),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), ($urandom % 3) == 0);
  endtask

  task automatic step(input string tag);
    logic s;
    logic [4:0] dest;
    #1;
    s = exp_stall();
    chk({tag, ":stall"}, 128'(load_use_stall), 128'(s));
    chk({tag, ":pc_we"}, 128'(pc_write_en), 128'(!(s || mem_stall)));
    chk({tag, ":ifid_we"}, 128'(if_id_write_en), 128'(!(s || mem_stall)));
    @(posedge clk);
    dest = id_reg_dst ? id_rd : id_rt;
    if (ex_flush) begin
      m = '0;
      fl = (fl < CMAX) ? fl + 1 : fl;
    end else if (mem_stall) begin
      m = m;
    end else if (s) begin
      m = '0;
      bub = (bub < CMAX) ? bub + 1 : bub;
    end else begin
      m = '{v: id_valid, rs: id_rs, rt: id_rt, wr: dest,
            rw: id_valid && id_reg_write && dest != 0, mr: id_valid && id_mem_read,
            mw: id_valid && id_mem_write, m2r: id_valid && id_mem_to_reg,
            as: id_valid && id_alu_src, op: id_valid ? id_alu_op : 4'd0,
            a: id_rs_data, b: id_rt_data, imm: id_imm};
    end
    @(negedge clk);
    chk({tag, ":ex"}, 128'(obs), 128'(m));
    chk({tag, ":bubble_cnt"}, 128'(bubble_cnt), 128'(bub));
    chk({tag, ":flush_cnt"}, 128'(flush_cnt), 128'(fl));
  endtask

  initial begin
    m = '0; bub = 0; fl = 0;
    mem_stall = 0; ex_flush = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst:ex", 128'(obs), 128'(0));
    chk("rst:pc_we", 128'(pc_write_en), 128'(1));
    rst_n = 1;

    set_id(1, 9, 8, 10, 1, 1, 1, 1, 0);
    step("t2a");
    chk("t2a:rs", 128'(ex_rs), 128'(9));
    chk("t2a:wr", 128'(ex_write_reg), 128'(10));
    chk("t2a:rw", 128'(ex_reg_write), 128'(1));
    set_id(1, 9, 8, 0, 1, 1, 1, 1, 0);
    step("t2b");
    chk("t2b:rw_r0", 128'(ex_reg_write), 128'(0));

    set_id(1, 4, 5, 6, 1, 1, 1, 1, 0);
    #1;
    rst_n = 0;
    #1;
    chk("t1:ex", 128'(obs), 128'(0));
    chk("t1:bubble_cnt", 128'(bubble_cnt), 128'(0));
    chk("t1:pc_we", 128'(pc_write_en), 128'(1));
    m = '0; bub = 0; fl = 0;
    @(negedge clk);
    rst_n = 1;

    set_id(1, 3, 7, 4, 1, 0, 0, 1, 1);
    step("t3lw");
    set_id(1, 7, 2, 5, 1, 1, 1, 1, 0);
    #1;
    chk("t3:stall_hi", 128'(load_use_stall), 128'(1));
    chk("t3:pc_we_lo", 128'(pc_write_en), 128'(0));
    step("t3bubble");
    chk("t3:ex_valid", 128'(ex_valid), 128'(0));
    chk("t3:bubble_cnt", 128'(bubble_cnt), 128'(1));
    step("t3cap");
    chk("t3:cap_rs", 128'(ex_rs), 128'(7));

    set_id(1, 1, 0, 0, 1, 1, 0, 1, 1);
    step("t4lw0");
    set_id(1, 0, 0, 3, 1, 1, 1, 1, 0);
    #1;
    chk("t4:rt0", 128'(load_use_stall), 128'(0));
    step("t4a");
    set_id(1, 3, 7, 4, 1, 0, 0, 1, 1);
    step("t4lw7");
    set_id(1, 3, 7, 2, 1, 0, 1, 1, 0);
    #1;
    chk("t4:no_use_rt", 128'(load_use_stall), 128'(0));
    step("t4b");

    set_id(1, 3, 7, 4, 1, 0, 0, 1, 1);
    step("t5lw");
    set_id(1, 7, 2, 5, 1, 1, 1, 1, 0);
    ex_flush = 1; mem_stall = 1;
    #1;
    chk("t5:stall", 128'(load_use_stall), 128'(0));
    step("t5");
    chk("t5:ex_valid", 128'(ex_valid), 128'(0));
    chk("t5:flush_cnt", 128'(flush_cnt), 128'(1));
    chk("t5:bubble_cnt", 128'(bubble_cnt), 128'(1));
    ex_flush = 0; mem_stall = 0;

    set_id(1, 2, 3, 4, 1, 1, 1, 1, 0);
    step("t6load");
    mem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      randomize_id();
      #1;
      chk("t6:pc_we", 128'(pc_write_en), 128'(0));
      step("t6hold");
    end
    mem_stall = 0;

    for (int i = 0; i < 400; i++) begin
      randomize_id();
      mem_stall = ($urandom % 6) == 0;
      ex_flush  = ($urandom % 10) == 0;
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
